md_sequencer: RTL and testbench

- Sequences the multi-cycle multiply/divide resource in the E stage.
- Accepts one MDU operation per start pulse and holds the HI/LO architectural registers.
- Counts out the fixed operation latency and raises md_stall, which the pipeline ORs into its global stall to freeze F/D and bubble E.
- mfhi/mflo read hi/lo directly; the sequencer guarantees they are never read while a result is pending.

---
 rtl/md_pkg.sv | 27 ++
 rtl/md_result_calc.sv | 71 +++++++
 rtl/md_sequencer.sv | 119 +++++++++++
 tb/tb_md_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, FSM states
// and the long-latency opcode set.
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // One bit per opcode; set for the multi-cycle ops (MULT, MULTU, DIV, DIVU).
  localparam logic [15:0] MD_OPS_LONG = 16'b0000_0000_0001_1110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_long_op(input logic [3:0] op);
    return MD_OPS_LONG[op];
  endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational 64-bit product and quotient/remainder for the MDU opcodes.
// A single unsigned divider is shared between DIV and DIVU via magnitudes.
module md_result_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_div;
  logic        in1_neg;
  logic        in2_neg;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod_s  = {{32{in1[31]}}, in1} * {{32{in2[31]}}, in2};
    prod_u  = {32'b0, in1} * {32'b0, in2};
    is_div  = (op == OP_DIV) || (op == OP_DIVU);

    // Signs only matter for DIV; DIVU feeds the raw operands through.
    in1_neg = (op == OP_DIV) && in1[31];
    in2_neg = (op == OP_DIV) && in2[31];
    dvd     = in1_neg ? (32'd0 - in1) : in1;
    dvs     = in2_neg ? (32'd0 - in2) : in2;

    div_by_zero = is_div && (in2 == 32'd0);
    if (dvs == 32'd0) begin
      quot = 32'd0;
      rem  = 32'd0;
    end else begin
      quot = dvd / dvs;
      rem  = dvd % dvs;
    end

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        // Quotient truncates toward zero; remainder follows the dividend sign.
        res_lo = (in1_neg ^ in2_neg) ? (32'd0 - quot) : quot;
        res_hi = in1_neg ? (32'd0 - rem) : rem;
      end
      OP_DIVU: begin
        res_lo = quot;
        res_hi = rem;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: holds HI/LO, counts out the fixed
// operation latency and raises md_stall for dependent D-stage MDU ops.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_dbz;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dbz_q, pend_dbz_d;
  logic             busy_q, busy_d;

  md_result_calc u_calc (
    .op          (op),
    .in1         (in1),
    .in2         (in2),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (res_dbz)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_dbz_d = pend_dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(op)) begin
            pend_hi_d  = res_hi;
            pend_lo_d  = res_lo;
            pend_dbz_d = res_dbz;
            cnt_d      = ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
            state_d    = ST_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = in1;
          end else if (op == OP_MTLO) begin
            lo_d = in1;
          end
        end
      end
      ST_RUN: begin
        // Any start while running is ignored; the pipeline stalls it anyway.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          if (!pend_dbz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      pend_hi_q  <= 32'd0;
      pend_lo_q  <= 32'd0;
      pend_dbz_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_dbz_q <= pend_dbz_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  // Combinational so a dependent D op is released in the cycle HI/LO are valid.
  assign md_stall = d_uses_md & (busy_q | (start & is_long_op(op)));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: inputs change on the falling edge and
// outputs are checked there, away from the rising active edge.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        d_uses_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  md_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .md_stall  (md_stall),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Accept an op in cycle T; returns at the falling edge of cycle T+1 with
  // the operands scrambled so capture-at-acceptance is exercised.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
    in1   = 32'hDEAD_BEEF;
    in2   = 32'h1234_5678;
  endtask

  // Checks busy for n cycles starting at T+1; returns at cycle T+n+1.
  task automatic expect_busy(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      check($sformatf("%s_busy_c%0d", tag, i), {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    check($sformatf("%s_busy_end", tag), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    op        = OP_NONE;
    in1       = 32'd0;
    in2       = 32'd0;
    d_uses_md = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, md_stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // MULT -2 * 3
    @(negedge clk);
    start = 1'b1; op = OP_MULT; in1 = 32'hFFFF_FFFE; in2 = 32'd3;
    @(negedge clk);
    start = 1'b0; op = OP_NONE; in1 = 32'h7; in2 = 32'h9;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("mult_busy_c%0d", i), {31'b0, busy}, 32'd1);
      if (i == 5) check("mult_hi_not_early", hi, 32'd0);
      @(negedge clk);
    end
    check("mult_busy_end", {31'b0, busy}, 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // DIVU 100 / 7 with a dependent D-stage MDU op
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; in1 = 32'd100; in2 = 32'd7; d_uses_md = 1'b1;
    #1 check("divu_stall_c0", {31'b0, md_stall}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0; op = OP_MFLO;
      #1 check($sformatf("divu_stall_c%0d", i), {31'b0, md_stall}, 32'd1);
    end
    @(negedge clk);
    #1;
    check("divu_stall_end", {31'b0, md_stall}, 32'd0);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);
    d_uses_md = 1'b0; op = OP_NONE;

    // DIV overflow corner
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_busy("div_ovf", 10);
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_lo", lo, 32'h8000_0000);

    // DIV -7 / 2 : quotient -3, remainder -1
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    expect_busy("div_neg", 10);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);

    // Unused opcode and MFHI leave state alone
    issue(4'd9, 32'h5555_5555, 32'd1);
    check("op9_busy", {31'b0, busy}, 32'd0);
    issue(OP_MFHI, 32'h6666_6666, 32'd1);
    check("mfhi_busy", {31'b0, busy}, 32'd0);
    check("mfhi_hi", hi, 32'hFFFF_FFFF);
    check("mfhi_lo", lo, 32'hFFFF_FFFD);

    // MTHI / MTLO then divide by zero
    issue(OP_MTHI, 32'h11, 32'd0);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h11);
    issue(OP_MTLO, 32'h22, 32'd0);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    check("mtlo_lo", lo, 32'h22);
    check("mtlo_hi", hi, 32'h11);
    issue(OP_DIV, 32'd5, 32'd0);
    expect_busy("div0", 10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // Reset mid-operation
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("rstmid_busy_c1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid_busy", {31'b0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_t6_busy", {31'b0, busy}, 32'd0);
    check("rstmid_t6_hi", hi, 32'd0);
    check("rstmid_t6_lo", lo, 32'd0);
    @(negedge clk);
    check("rstmid_t7_lo", lo, 32'd0);

    // Start forced during RUN is ignored
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("ign_busy_c%0d", i), {31'b0, busy}, 32'd1);
      @(negedge clk);
      start = (i == 1);
      op    = OP_MULT;
      in1   = 32'd2;
      in2   = 32'd3;
    end
    op = OP_NONE;
    check("ign_busy_end", {31'b0, busy}, 32'd0);
    check("ign_hi", hi, 32'd1);
    check("ign_lo", lo, 32'd0);
    @(negedge clk);
    check("ign_busy_after", {31'b0, busy}, 32'd0);
    check("ign_hi_after", hi, 32'd1);
    check("ign_lo_after", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
